// File: rtl/pulse_stretcher.sv
// Stretches one-cycle event strobes into ON_CYCLES-long high levels, each followed by a GAP_CYCLES low gap.
// A strobe sampled in IDLE raises level_out on the next edge. There is no backpressure: events that arrive while a flash runs are queued, and are dropped with an overflow pulse only when the queue is full.
module pulse_stretcher #(
    parameter int ON_CYCLES  = 12_500_000,
    parameter int GAP_CYCLES = 12_500_000,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0]     ON_LOAD   = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]     GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]     TIMER_ONE = TW'(1);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TW-1:0]       timer;
    logic [TW-1:0]       timer_nxt;
    logic [PEND_W-1:0]   pending_nxt;
    logic                overflow_nxt;
    logic                dec;
    logic                bypass;
    logic                inc;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        dec       = 1'b0;
        bypass    = 1'b0;
        case (state)
            S_IDLE: begin
                // A queued event has priority; a strobe arriving alongside it is queued instead.
                if (pending != '0) begin
                    state_nxt = S_ON;
                    timer_nxt = ON_LOAD;
                    dec       = 1'b1;
                end else if (pulse_in) begin
                    state_nxt = S_ON;
                    timer_nxt = ON_LOAD;
                    bypass    = 1'b1;
                end
            end
            S_ON: begin
                if (timer == '0) begin
                    state_nxt = S_GAP;
                    timer_nxt = GAP_LOAD;
                end else begin
                    timer_nxt = timer - TIMER_ONE;
                end
            end
            S_GAP: begin
                if (timer == '0) begin
                    if (pending != '0) begin
                        state_nxt = S_ON;
                        timer_nxt = ON_LOAD;
                        dec       = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    timer_nxt = timer - TIMER_ONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    always_comb begin
        inc          = pulse_in & ~bypass;
        pending_nxt  = pending;
        overflow_nxt = 1'b0;
        if (inc && !dec) begin
            if (pending == PEND_MAX) begin
                overflow_nxt = 1'b1;
            end else begin
                pending_nxt = pending + PEND_ONE;
            end
        end else if (dec && !inc) begin
            pending_nxt = pending - PEND_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            level_out <= 1'b0;
            busy      <= 1'b0;
            pending   <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            level_out <= (state_nxt == S_ON);
            busy      <= (state_nxt != S_IDLE);
            pending   <= pending_nxt;
            overflow  <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Random and directed strobes are scheduled as flash start times by an event-level model; a monitor pops the expectations against the DUT.
module tb_pulse_stretcher;

    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int PW   = 2;
    localparam int PMAX = 3;
    localparam int INF  = 32'h7fff_ffff;
    localparam int LAST = 3000;
    localparam int DRAIN = 3100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pulse_in = 1'b0;
    logic          level_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    pulse_stretcher #(
        .ON_CYCLES (ON),
        .GAP_CYCLES(GAP),
        .PEND_W    (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .level_out(level_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   c;
        logic lv;
        logic bz;
        int   pd;
        logic ov;
    } exp_t;

    exp_t exp_q[$];
    int   start_q[$];
    int   checks = 0;
    int   errors = 0;

    int dir_pulse [17] = '{10, 40, 42, 70, 71, 72, 73, 74, 190, 192, 196,
                           250, 251, 252, 300, 301, 302};

    // Event-level model: future flash start times, the current flash and the first cycle a new strobe could bypass the queue.
    int   fut[$];
    int   cur_start = -1000;
    int   trunc = -1000;
    int   free_at = 0;
    logic ovf_n;
    int   c;
    int   p_now;
    int   s;
    int   hold = 0;
    int   mode;
    bit   dec;
    logic p;
    logic r;
    exp_t e;

    initial begin
        while (cyc < DRAIN) begin
            @(posedge clk);
            #2;
            c = cyc;
            p = 1'b0;
            r = 1'b0;
            if (c < 4 || c == 253) begin
                r = 1'b1;
            end else if (c < 340) begin
                foreach (dir_pulse[i]) if (dir_pulse[i] == c) p = 1'b1;
            end else if (c <= LAST) begin
                mode = (c / 250) % 4;
                case (mode)
                    0: p = ($urandom % 2) == 0;
                    1: p = ($urandom % 12) == 0;
                    2: begin
                        if (hold == 0 && ($urandom % 30) == 0) hold = $urandom_range(5, 1);
                        p = (hold > 0);
                        if (hold > 0) hold--;
                    end
                    default: begin
                        p = ($urandom % 3) == 0;
                        r = ($urandom % 97) == 0;
                    end
                endcase
            end
            rst      = r;
            pulse_in = p;

            ovf_n = 1'b0;
            if (r) begin
                fut.delete();
                while (start_q.size() > 0 && start_q[$] > c) void'(start_q.pop_back());
                trunc   = c + 1;
                free_at = c + 1;
            end else begin
                p_now = fut.size();
                dec   = 1'b0;
                if (p_now > 0 && fut[0] == c + 1) begin
                    void'(fut.pop_front());
                    cur_start = c + 1;
                    trunc     = INF;
                    dec       = 1'b1;
                end
                if (p) begin
                    if (c >= free_at) begin
                        cur_start = c + 1;
                        trunc     = INF;
                        start_q.push_back(c + 1);
                        free_at = c + 1 + ON + GAP;
                    end else if (p_now == PMAX && !dec) begin
                        ovf_n = 1'b1;
                    end else begin
                        // A queued event can launch no earlier than one cycle after it is counted.
                        s = (free_at > c + 2) ? free_at : c + 2;
                        fut.push_back(s);
                        start_q.push_back(s);
                        free_at = s + ON + GAP;
                    end
                end
            end
            e.c  = c + 1;
            e.lv = (e.c >= cur_start) && (e.c < cur_start + ON) && (e.c < trunc);
            e.bz = (e.c >= cur_start) && (e.c < cur_start + ON + GAP) && (e.c < trunc);
            e.pd = fut.size();
            e.ov = ovf_n;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (start_q.size() != 0) begin
            errors++;
            $display("FAIL flash_drain: %0d flashes never started, expected 0", start_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic prev;
        exp_t m;
        int   st;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                m = exp_q.pop_front();
                errors++;
                $display("FAIL stale_expect: cycle %0d unchecked at cycle %0d", m.c, cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                m = exp_q.pop_front();
                checks++;
                if (level_out !== m.lv || busy !== m.bz || pending !== 2'(m.pd) || overflow !== m.ov) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got lvl=%b busy=%b pend=%0d ovf=%b expected lvl=%b busy=%b pend=%0d ovf=%b",
                             cyc, level_out, busy, pending, overflow, m.lv, m.bz, m.pd, m.ov);
                end
            end
            if (level_out === 1'b1 && prev !== 1'b1) begin
                checks++;
                if (start_q.size() == 0) begin
                    errors++;
                    $display("FAIL flash_start: unexpected flash at cycle %0d, none expected", cyc);
                end else begin
                    st = start_q.pop_front();
                    if (st != cyc) begin
                        errors++;
                        $display("FAIL flash_start: flash at cycle %0d, expected cycle %0d", cyc, st);
                    end
                end
            end
            prev = level_out;
        end
    end

endmodule
